// File: rtl/interval_meter.sv
// Interval meter: counts ticks between a start event and a stop event and hands the
// duration out over valid/ready. Optional INTERVAL_PRESCALER_EN derives ticks from clk/DIV.
module interval_meter #(
    parameter int W   = 13,
    parameter int DIV = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_en,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    output logic [W-1:0] meas,
    output logic         meas_valid,
    input  logic         meas_ready,
    output logic         busy,
    output logic         ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    state_t       state_r, state_nxt_s;
    logic [W-1:0] cnt_r, cnt_nxt_s;
    logic [W-1:0] meas_r, meas_nxt_s;
    logic [W:0]   inc_s;
    logic         sat_r, sat_nxt_s;
    logic         valid_r, valid_nxt_s;
    logic         ovf_r, ovf_nxt_s;
    logic         busy_r;
    logic         start_q_r, stop_q_r;
    logic         start_e_s, stop_e_s;
    logic         tick_s;
    logic         accept_start_s;

    // Saturating increment; MSB of the result flags an attempt to step past the maximum.
    function automatic logic [W:0] sat_inc(input logic [W-1:0] v);
        if (v == CNT_MAX) begin
            return {1'b1, CNT_MAX};
        end else begin
            return {1'b0, v + W'(1'b1)};
        end
    endfunction

    assign start_e_s = start & ~start_q_r;
    assign stop_e_s  = stop & ~stop_q_r;
    assign inc_s     = sat_inc(cnt_r);

`ifdef INTERVAL_PRESCALER_EN
    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_r;
    logic          unused_tick_en_s;

    assign unused_tick_en_s = tick_en;
    assign tick_s           = (pre_r == PRE_LAST);

    // Prescaler restarts on an accepted start so the first tick lands exactly DIV clks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= {PW{1'b0}};
        end else if (clear || accept_start_s || tick_s) begin
            pre_r <= {PW{1'b0}};
        end else begin
            pre_r <= pre_r + PW'(1'b1);
        end
    end
`else
    localparam int unused_div = DIV;

    assign tick_s = tick_en;
`endif

    // Event edge detectors sample the raw levels every cycle, clear included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q_r <= 1'b0;
            stop_q_r  <= 1'b0;
        end else begin
            start_q_r <= start;
            stop_q_r  <= stop;
        end
    end

    // Next-state and datapath decisions; clear overrides every state transition.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        sat_nxt_s      = sat_r;
        meas_nxt_s     = meas_r;
        valid_nxt_s    = valid_r;
        ovf_nxt_s      = ovf_r;
        accept_start_s = 1'b0;
        if (clear) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            sat_nxt_s   = 1'b0;
            valid_nxt_s = 1'b0;
            ovf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_e_s) begin
                        accept_start_s = 1'b1;
                        cnt_nxt_s      = CNT_ZERO;
                        sat_nxt_s      = 1'b0;
                        if (stop_e_s) begin
                            meas_nxt_s  = CNT_ZERO;
                            ovf_nxt_s   = 1'b0;
                            valid_nxt_s = 1'b1;
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        cnt_nxt_s = inc_s[W-1:0];
                        sat_nxt_s = sat_r | inc_s[W];
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    // A tick coinciding with stop is part of the interval.
                    if (stop_e_s) begin
                        meas_nxt_s  = cnt_nxt_s;
                        ovf_nxt_s   = sat_nxt_s;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (valid_r && meas_ready) begin
                        valid_nxt_s = 1'b0;
                        if (start_e_s) begin
                            accept_start_s = 1'b1;
                            cnt_nxt_s      = CNT_ZERO;
                            sat_nxt_s      = 1'b0;
                            state_nxt_s    = ST_RUN;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    sat_nxt_s   = 1'b0;
                    valid_nxt_s = 1'b0;
                    ovf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            sat_r   <= 1'b0;
            meas_r  <= CNT_ZERO;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sat_r   <= sat_nxt_s;
            meas_r  <= meas_nxt_s;
            valid_r <= valid_nxt_s;
            ovf_r   <= ovf_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
        end
    end

    assign meas       = meas_r;
    assign meas_valid = valid_r;
    assign ovf        = ovf_r;
    assign busy       = busy_r;

endmodule
